// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, width helpers and status types for the audio
// frame FIFO. Build option AUDIO_FIFO_FWFT_EN (see audio_frame_fifo) does not
// affect anything in this package.
package audio_pkg;

  // Default frame geometry: stereo, 24-bit samples.
  localparam int SAMPLE_W_DEF = 24;
  localparam int CHANNELS_DEF = 2;

  // Sticky error status, kept together so set/clear logic treats both alike.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Width of one frame: all channel samples side by side, channel 0 in LSBs.
  function automatic int frame_w(input int sample_w, input int channels);
    return sample_w * channels;
  endfunction

  // Width needed to count 0..depth stored frames inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// fifo_ram_1r1w: one-write/one-read frame storage for audio_frame_fifo.
// Write is synchronous. Read is registered by default; with AUDIO_FIFO_FWFT_EN
// defined the read port is combinational so the head frame is always visible.
module fifo_ram_1r1w #(
  parameter int WIDTH  = 48,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming frame at the write address.
  // NOTE: the array has no reset; clearing it would block RAM inference, and
  // the controller never exposes a location that has not been written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef AUDIO_FIFO_FWFT_EN
  // Head frame is presented continuously; the controller masks it when empty.
  assign rd_data = mem[raddr];
`else
  // Capture the addressed frame on an accepted read, otherwise hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[raddr];
  end
`endif

endmodule

// File: rtl/audio_frame_fifo.sv
// audio_frame_fifo: synchronous FIFO of multi-channel audio frames with
// occupancy level, watermark flags, sticky overflow/underflow and flush.
// Build option: define AUDIO_FIFO_FWFT_EN for first-word-fall-through reads;
// otherwise r_data updates one cycle after an accepted read.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 w_en,
  input  logic [frame_w(SAMPLE_W, CHANNELS)-1:0] w_data,
  output logic                                 w_full,
  input  logic                                 r_en,
  output logic [frame_w(SAMPLE_W, CHANNELS)-1:0] r_data,
  output logic                                 r_empty,
  output logic [level_w(DEPTH)-1:0]            level,
  output logic                                 almost_full,
  output logic                                 almost_empty,
  output logic                                 overflow,
  output logic                                 underflow,
  input  logic                                 err_clr
);

  localparam int FRAME_W = frame_w(SAMPLE_W, CHANNELS);
  localparam int LEVEL_W = level_w(DEPTH);
  localparam int ADDR_W  = $clog2(DEPTH);
  // One extra wrap bit so equal addresses can still be told apart by lap.
  localparam int PTR_W   = ADDR_W + 1;

  localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] AF_LVL   = LEVEL_W'(AF_THRESH);
  localparam logic [LEVEL_W-1:0] AE_LVL   = LEVEL_W'(AE_THRESH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               wr_acc;
  logic               rd_acc;
  logic               ov_evt;
  logic               un_evt;
  fifo_err_t          err_q;
  fifo_err_t          err_d;
  logic [FRAME_W-1:0] ram_rd_data;

  // Status flags come straight from the registered level.
  assign w_full       = (level == FULL_LVL);
  assign r_empty      = (level == '0);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // Each side is accepted only if its own flag allows it; flush blocks both.
  assign wr_acc = w_en && !w_full  && !flush;
  assign rd_acc = r_en && !r_empty && !flush;

  // Requests refused by a flag are errors; a flush cycle ignores requests.
  assign ov_evt = w_en && w_full  && !flush;
  assign un_evt = r_en && r_empty && !flush;

  // Pointer and occupancy bookkeeping; flush restarts from an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Next sticky error state: a new error in the same cycle beats err_clr.
  always_comb begin
    // NOTE: default first so every path assigns err_d and no latch is built.
    err_d = err_q;
    if (!flush) begin
      if (ov_evt)       err_d.overflow  = 1'b1;
      else if (err_clr) err_d.overflow  = 1'b0;
      if (un_evt)       err_d.underflow = 1'b1;
      else if (err_clr) err_d.underflow = 1'b0;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;

  // Occupancy must always equal the distance between the wrap-extended pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (level == LEVEL_W'(wr_ptr - rd_ptr))
        else $error("level/pointer distance disagree");
    end
  end

  fifo_ram_1r1w #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_acc),
    .waddr   (wr_ptr[ADDR_W-1:0]),
    .wdata   (w_data),
    .re      (rd_acc),
    .raddr   (rd_ptr[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

`ifdef AUDIO_FIFO_FWFT_EN
  // Unwritten or discarded storage is never shown: empty reads as zero.
  assign r_data = r_empty ? '0 : ram_rd_data;
`else
  assign r_data = ram_rd_data;
`endif

endmodule

// File: tb/tb_audio_frame_fifo.sv
// tb_audio_frame_fifo: scoreboard bench for audio_frame_fifo at
// SAMPLE_W=24, CHANNELS=2, DEPTH=8, AF_THRESH=6, AE_THRESH=2.
// Follows AUDIO_FIFO_FWFT_EN the same way the design does.
module tb_audio_frame_fifo;

  localparam int SAMPLE_W = 24;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 8;
  localparam int AF       = 6;
  localparam int AE       = 2;
  localparam int FW       = SAMPLE_W * CHANNELS;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          flush   = 1'b0;
  logic          w_en    = 1'b0;
  logic          r_en    = 1'b0;
  logic          err_clr = 1'b0;
  logic [FW-1:0] w_data  = '0;
  logic [FW-1:0] r_data;
  logic [LW-1:0] level;
  logic          w_full, r_empty, almost_full, almost_empty, overflow, underflow;

  int            n_checks = 0;
  int            n_errs   = 0;

  // Reference model state.
  int            m_level;
  logic          m_ov, m_un;
  logic [FW-1:0] m_rdata;
  logic [FW-1:0] sb_q[$];

  always #5 clk = ~clk;

  audio_frame_fifo #(
    .SAMPLE_W  (SAMPLE_W),
    .CHANNELS  (CHANNELS),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .w_en         (w_en),
    .w_data       (w_data),
    .w_full       (w_full),
    .r_en         (r_en),
    .r_data       (r_data),
    .r_empty      (r_empty),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame k: both channels carry k.
  function automatic logic [FW-1:0] frm(input int k);
    return {SAMPLE_W'(k), SAMPLE_W'(k)};
  endfunction

  function automatic logic [FW-1:0] exp_rdata();
`ifdef AUDIO_FIFO_FWFT_EN
    return (m_level == 0) ? '0 : sb_q[0];
`else
    return m_rdata;
`endif
  endfunction

  task automatic model_reset();
    m_level = 0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
    m_rdata = '0;
    sb_q.delete();
  endtask

  task automatic check_state(input string where);
    check({where, ".level"},  64'(level),        64'(m_level));
    check({where, ".empty"},  64'(r_empty),      64'(m_level == 0));
    check({where, ".full"},   64'(w_full),       64'(m_level == DEPTH));
    check({where, ".afull"},  64'(almost_full),  64'(m_level >= AF));
    check({where, ".aempty"}, 64'(almost_empty), 64'(m_level <= AE));
    check({where, ".ovf"},    64'(overflow),     64'(m_ov));
    check({where, ".unf"},    64'(underflow),    64'(m_un));
    check({where, ".rdata"},  64'(r_data),       64'(exp_rdata()));
  endtask

  // One clock: drive at negedge, predict, clock, compare at next negedge.
  task automatic cycle(input string where, input logic we, input logic [FW-1:0] wd,
                       input logic re, input logic fl, input logic ec);
    bit            wacc, racc;
    logic [FW-1:0] head;
    w_en = we; w_data = wd; r_en = re; flush = fl; err_clr = ec;
    wacc = we && (m_level != DEPTH) && !fl;
    racc = re && (m_level != 0) && !fl;
    if (!fl) begin
      if (we && m_level == DEPTH) m_ov = 1'b1;
      else if (ec)                m_ov = 1'b0;
      if (re && m_level == 0)     m_un = 1'b1;
      else if (ec)                m_un = 1'b0;
    end
`ifdef AUDIO_FIFO_FWFT_EN
    if (racc) check({where, ".head"}, 64'(r_data), 64'(sb_q[0]));
`endif
    @(posedge clk);
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    if (fl) begin
      sb_q.delete();
      m_level = 0;
    end else begin
      if (racc) begin
        head    = sb_q.pop_front();
        m_rdata = head;
`ifndef AUDIO_FIFO_FWFT_EN
        check({where, ".order"}, 64'(r_data), 64'(head));
`endif
      end
      if (wacc) sb_q.push_back(wd);
      m_level = m_level + int'(wacc) - int'(racc);
    end
    check_state(where);
  endtask

  // Assert reset between edges while a write is being presented.
  task automatic reset_mid(input logic [FW-1:0] wd);
    w_en = 1'b1; w_data = wd;
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_en = 1'b0;
    rst  = 1'b0;
    model_reset();
    check_state("rst_mid");
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_state("reset");

    // Make r_data non-zero so the mid-burst reset visibly clears it.
    cycle("pre_wr", 1'b1, 48'hAAAAAA_555555, 1'b0, 1'b0, 1'b0);
    cycle("pre_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Burst of 5 writes interrupted by reset on the 5th.
    for (int k = 1; k <= 4; k++) cycle("burst", 1'b1, frm(k), 1'b0, 1'b0, 1'b0);
    reset_mid(frm(5));

    // Fill to full, then one overflowing write.
    for (int k = 1; k <= 8; k++) cycle("fill", 1'b1, frm(k), 1'b0, 1'b0, 1'b0);
    cycle("ovf", 1'b1, frm(9), 1'b0, 1'b0, 1'b0);

    // err_clr together with another overflowing write keeps the flag set.
    cycle("clr_vs_ovf", 1'b1, frm(10), 1'b0, 1'b0, 1'b1);
    cycle("clr_ovf", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Drain in order, then one read too many.
    for (int k = 1; k <= 8; k++) cycle("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("unf", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("clr_unf", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Read and write together while empty: only the write is taken.
    cycle("empty_wr", 1'b1, frm(32'h50), 1'b1, 1'b0, 1'b0);
    cycle("empty_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Steady state at level 4 with simultaneous traffic; pointers wrap.
    for (int k = 0; k < 4; k++) cycle("lvl4", 1'b1, frm(32'h100 + k), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("both", 1'b1, frm(32'h200 + i), 1'b1, 1'b0, 1'b0);

    // Level 5, then flush with both requests high.
    cycle("lvl5", 1'b1, frm(32'h300), 1'b0, 1'b0, 1'b0);
    cycle("flush", 1'b1, frm(32'h301), 1'b1, 1'b1, 1'b0);

    // Post-flush traffic returns only new data.
    cycle("post_wr", 1'b1, frm(32'h400), 1'b0, 1'b0, 1'b0);
    cycle("post_wr", 1'b1, frm(32'h401), 1'b0, 1'b0, 1'b0);
    cycle("post_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("post_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
